// File: rtl/led_bar_pkg.sv
// Shared types and constants for the LED bar step controller.
// The bar is active-low: a lit LED is a 0 bit.
package led_bar_pkg;

    typedef enum logic [1:0] {
        REL_WAIT   = 2'd0,
        IDLE       = 2'd1,
        PRESS_WAIT = 2'd2,
        HELD       = 2'd3
    } btn_state_t;

    localparam logic [3:0] MAX_LEVEL   = 4'd8;
    localparam logic [7:0] LED_ALL_OFF = 8'hFF;
    localparam logic [7:0] LED_ALL_ON  = 8'h00;

    // Levels above MAX_LEVEL never reach the bar; they shift every LED on.
    function automatic logic [7:0] led_pattern(input logic [3:0] lvl);
        return (lvl > MAX_LEVEL) ? LED_ALL_ON : (LED_ALL_OFF << lvl);
    endfunction

endpackage

// File: rtl/led_bar_btn_debounce.sv
// Push-button synchroniser and debouncer; emits a single-cycle press pulse
// once a low level has been stable long enough, and only after a clean release.
module btn_debounce
    import led_bar_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw_n,
    output logic o_press
);

    logic [1:0]       r_sync;
    logic [DEB_W-1:0] r_cnt;
    btn_state_t       r_state;
    logic             r_press;
    logic             w_s;

    assign w_s     = r_sync[1];
    assign o_press = r_press;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_state <= REL_WAIT;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_sw_n};
            r_press <= 1'b0;
            case (r_state)
                REL_WAIT: begin
                    if (!w_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (!w_s) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    // The low sample that left IDLE is the first of the stable run.
                    if (w_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_W'(DEB_CYCLES - 2)) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (w_s) begin
                        r_state <= REL_WAIT;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= REL_WAIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/led_bar_step_controller.sv
// LED bar sequencer: merges debounced button presses and auto-run ticks into
// single step events and holds the bar level and its active-low pattern.
module led_bar_step_controller
    import led_bar_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int TICK_CYCLES = 50,
    parameter int DEB_W       = 20,
    parameter int TICK_W      = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_n,
    input  logic       mode_auto,
    input  logic       dir_up,
    output logic [7:0] led_out,
    output logic [3:0] level,
    output logic       step_pulse,
    output logic       wrap_pulse,
    output logic       paused
);

    logic [TICK_W-1:0] r_pre;
    logic              r_tick;
    logic              r_paused;
    logic [3:0]        r_level;
    logic [7:0]        r_led;
    logic              r_step;
    logic              r_wrap;

    logic              w_press;
    logic              w_run;
    logic              w_step_req;
    logic [3:0]        w_nxt_level;
    logic              w_nxt_wrap;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_btn (
        .clk     (clk),
        .reset   (reset),
        .i_sw_n  (sw_n),
        .o_press (w_press)
    );

    assign w_run      = mode_auto & ~r_paused;
    // Tick is registered, so a tick issued just before a switch to manual still
    // lands and merges with a press arriving in that same cycle.
    assign w_step_req = (w_press & ~mode_auto) | r_tick;

    always_comb begin
        w_nxt_level = r_level;
        w_nxt_wrap  = 1'b0;
        if (r_level > MAX_LEVEL) begin
            w_nxt_level = 4'd0;
        end else if (dir_up) begin
            if (r_level == MAX_LEVEL) begin
                w_nxt_level = 4'd0;
                w_nxt_wrap  = 1'b1;
            end else begin
                w_nxt_level = r_level + 4'd1;
            end
        end else begin
            if (r_level == 4'd0) begin
                w_nxt_level = MAX_LEVEL;
                w_nxt_wrap  = 1'b1;
            end else begin
                w_nxt_level = r_level - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre    <= '0;
            r_tick   <= 1'b0;
            r_paused <= 1'b0;
            r_level  <= 4'd0;
            r_led    <= LED_ALL_OFF;
            r_step   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            if (!w_run || r_pre == TICK_W'(TICK_CYCLES - 1))
                r_pre <= '0;
            else
                r_pre <= r_pre + 1'b1;
            r_tick <= w_run && (r_pre == TICK_W'(TICK_CYCLES - 1));

            if (!mode_auto)
                r_paused <= 1'b0;
            else if (w_press)
                r_paused <= ~r_paused;

            r_step <= w_step_req;
            r_wrap <= w_step_req & w_nxt_wrap;
            if (w_step_req) begin
                r_level <= w_nxt_level;
                r_led   <= led_pattern(w_nxt_level);
            end
        end
    end

    assign led_out    = r_led;
    assign level      = r_level;
    assign step_pulse = r_step;
    assign wrap_pulse = r_wrap;
    assign paused     = r_paused;

endmodule
